// File: rtl/disp_pkg.sv
// Shared types and helpers for the 7-segment display stage.
package disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_LOAD
  } state_t;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic        DP_OFF     = 1'b1;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] seg_lut(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd16.sv
// Sequential double-dabble: 16-bit binary to 20-bit BCD, one bit per cycle.
module bin2bcd16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bin,
  output logic [19:0] bcd,
  output logic        done
);

  logic [35:0] r_shift;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [35:0] w_adj;

  always_comb begin
    w_adj = r_shift;
    for (int unsigned i = 0; i < 5; i++) begin
      if (r_shift[16 + 4*i +: 4] >= 4'd5)
        w_adj[16 + 4*i +: 4] = r_shift[16 + 4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_shift <= {{20{1'b0}}, bin};
        r_cnt   <= '0;
        r_busy  <= 1'b1;
      end else if (r_busy) begin
        r_shift <= {w_adj[34:0], 1'b0};
        r_cnt   <= r_cnt + 4'd1;
        if (r_cnt == 4'd15) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign bcd  = r_shift[35:16];
  assign done = r_done;

endmodule

// File: rtl/disp_7seg.sv
// Captures one stream sample, optionally converts to BCD, and scans it onto a
// 4-digit common-anode 7-segment display.
module disp_7seg
  import disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_in,
  input  logic        d_valid,
  input  logic        dec_mode,
  output logic        d_ready,
  output logic [3:0]  an,
  output logic [7:0]  dec_cat
);

  localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  state_t          r_state, w_next;
  logic [15:0]     r_data;
  logic            r_mode;
  logic [3:0]      r_iter;
  logic [15:0]     r_disp;
  logic            r_ovf;
  logic [CW-1:0]   r_refresh;
  logic [1:0]      r_digit;
  logic [3:0]      r_an;
  logic [7:0]      r_cat;
  logic            w_capture;
  logic [19:0]     w_bcd;
  logic            w_done;
  logic [3:0]      w_nib;
  logic            w_dp;

  assign w_capture = (r_state == ST_IDLE) && d_valid;

  // The converter loads d_in on the capture edge so its 16 iterations line up
  // exactly with the 16 CONV cycles.
  bin2bcd16 u_bin2bcd16 (
    .clk   (clk),
    .rst   (rst),
    .start (w_capture && dec_mode),
    .bin   (d_in),
    .bcd   (w_bcd),
    .done  (w_done)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (d_valid) w_next = dec_mode ? ST_CONV : ST_LOAD;
      ST_CONV: if (r_iter == 4'd15) w_next = ST_LOAD;
      ST_LOAD: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_mode  <= 1'b0;
      r_iter  <= '0;
      r_disp  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_iter  <= (r_state == ST_CONV) ? r_iter + 4'd1 : '0;
      if (w_capture) begin
        r_data <= d_in;
        r_mode <= dec_mode;
      end
      if (r_state == ST_LOAD) begin
        if (!r_mode) begin
          r_disp <= r_data;
          r_ovf  <= 1'b0;
        end else if (w_done) begin
          r_disp <= w_bcd[15:0];
          r_ovf  <= |w_bcd[19:16];
        end
      end
    end
  end

  assign d_ready = (r_state == ST_IDLE);

  assign w_nib = r_disp[4*r_digit +: 4];
  assign w_dp  = (r_digit == 2'(NUM_DIGITS - 1) && r_ovf) ? ~DP_OFF : DP_OFF;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_refresh <= '0;
      r_digit   <= '0;
      r_an      <= 4'b1110;
      r_cat     <= 8'hC0;
    end else begin
      if (r_refresh == CW'(REFRESH_DIV - 1)) begin
        r_refresh <= '0;
        r_digit   <= r_digit + 2'd1;
      end else begin
        r_refresh <= r_refresh + CW'(1);
      end
      r_an  <= ~(4'b0001 << r_digit);
      r_cat <= {w_dp, seg_lut(w_nib)};
    end
  end

  assign an      = r_an;
  assign dec_cat = r_cat;

endmodule

// File: tb/tb_disp_7seg.sv
// Directed bench for disp_7seg with a scoreboard of expected scan frames.
module tb_disp_7seg;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] d_in;
  logic        d_valid;
  logic        dec_mode;
  logic        d_ready;
  logic [3:0]  an;
  logic [7:0]  dec_cat;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] cat;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_mis = 0;

  disp_7seg #(.REFRESH_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .d_in     (d_in),
    .d_valid  (d_valid),
    .dec_mode (dec_mode),
    .d_ready  (d_ready),
    .an       (an),
    .dec_cat  (dec_cat)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] seg_code(input int unsigned n);
    logic [7:0] t [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return t[n];
  endfunction

  task automatic push_frame(input int unsigned val, input bit dec);
    int unsigned dig, v;
    bit ovf;
    exp_t e;
    ovf = dec && (val > 9999);
    v   = dec ? (val % 10000) : val;
    for (int unsigned d = 0; d < 4; d++) begin
      dig = dec ? (v / (10 ** d)) % 10 : (v >> (4*d)) & 4'hF;
      e.an  = ~(4'b0001 << d);
      e.cat = seg_code(dig);
      if (d == 3 && ovf) e.cat[7] = 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_mis++;
    $error("FAIL %s timeout waiting for DUT", tag);
  endtask

  // Drive one sample at a negedge; returns after the capture posedge.
  task automatic send(input logic [15:0] v, input logic dm);
    @(negedge clk);
    d_in = v; dec_mode = dm; d_valid = 1'b1;
    @(posedge clk);
    #1 d_valid = 1'b0;
  endtask

  // Counts negedges on which d_ready is low.
  task automatic busy_cycles(output int cnt);
    cnt = 0;
    @(negedge clk);
    while (d_ready === 1'b0 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  // Align to the first cycle of digit 0 and check one full frame from the queue.
  task automatic check_frame(input string tag);
    int guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (an !== 4'b0111 && guard < 100) begin @(negedge clk); guard++; end
    while (an !== 4'b1110 && guard < 100) begin @(negedge clk); guard++; end
    if (guard >= 100) begin
      timeout({tag, "_sync"});
      q.delete();
      return;
    end
    for (int d = 0; d < 4; d++) begin
      if (q.size() == 0) begin
        timeout({tag, "_empty_queue"});
        return;
      end
      e = q.pop_front();
      for (int c = 0; c < 4; c++) begin
        if (!(d == 0 && c == 0)) @(negedge clk);
        chk($sformatf("%s_an_d%0d_c%0d", tag, d, c), {4'h0, an}, {4'h0, e.an});
        chk($sformatf("%s_cat_d%0d_c%0d", tag, d, c), dec_cat, e.cat);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int cnt;
    rst = 1'b0; d_in = '0; d_valid = 1'b0; dec_mode = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_an", {4'h0, an}, 8'h0E);
    chk("rst_cat", dec_cat, 8'hC0);
    chk("rst_ready", {7'h0, d_ready}, 8'h01);
    rst = 1'b1;
    push_frame(0, 1'b0);
    check_frame("reset_frame");

    send(16'h1A2F, 1'b0);
    busy_cycles(cnt);
    chk("hex_busy", 8'(cnt), 8'd1);
    push_frame(16'h1A2F, 1'b0);
    check_frame("hex_1A2F");

    send(16'd1234, 1'b1);
    busy_cycles(cnt);
    chk("dec_busy", 8'(cnt), 8'd17);
    push_frame(1234, 1'b1);
    check_frame("dec_1234");

    send(16'd65535, 1'b1);
    busy_cycles(cnt);
    chk("ovf_busy", 8'(cnt), 8'd17);
    push_frame(65535, 1'b1);
    check_frame("dec_65535");

    send(16'd1234, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("drop_ready_low", {7'h0, d_ready}, 8'h00);
    d_in = 16'h0007; dec_mode = 1'b0; d_valid = 1'b1;
    @(posedge clk);
    #1 d_valid = 1'b0;
    busy_cycles(cnt);
    chk("drop_busy_rest", 8'(cnt), 8'd12);
    push_frame(1234, 1'b1);
    check_frame("drop_keep_1234");

    send(16'd4321, 1'b1);
    repeat (8) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_an", {4'h0, an}, 8'h0E);
    chk("midrst_cat", dec_cat, 8'hC0);
    chk("midrst_ready", {7'h0, d_ready}, 8'h01);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    push_frame(0, 1'b0);
    check_frame("after_midrst");

    send(16'hBEEF, 1'b0);
    busy_cycles(cnt);
    chk("beef_busy", 8'(cnt), 8'd1);
    push_frame(16'hBEEF, 1'b0);
    check_frame("hex_BEEF");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
